// File: rtl/ent_word_collector_pkg.sv
// Shared constants for the entropy word collector: register map, bit fields
// and collect-FSM state encoding.
package ent_word_collector_pkg;

  localparam logic [7:0] ADDR_CTRL     = 8'h00;
  localparam logic [7:0] ADDR_STATUS   = 8'h01;
  localparam logic [7:0] ADDR_PRESCALE = 8'h02;
  localparam logic [7:0] ADDR_DATA     = 8'h03;
  localparam logic [7:0] ADDR_OVERFLOW = 8'h04;

  localparam int CTRL_ENABLE_BIT  = 0;
  localparam int STATUS_AVAIL_BIT = 0;
  localparam int STATUS_FULL_BIT  = 1;
  localparam int STATUS_COUNT_LSB = 8;
  localparam int STATUS_COUNT_MSB = 12;

  typedef enum logic [1:0] {
    CTRL_IDLE   = 2'd0,
    CTRL_SAMPLE = 2'd1,
    CTRL_PUSH   = 2'd2
  } ctrl_state_e;

endpackage

// File: rtl/ent_sync_fifo.sv
// Synchronous 32-bit FIFO with a separate occupancy counter. A pop of an empty
// FIFO is ignored; a push into a full FIFO is accepted only alongside a pop.
module ent_sync_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [31:0]              wdata,
  output logic [31:0]              rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; the pointers and count define
  // validity, and an unreset array maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/ent_word_collector.sv
// Samples a synchronised noise bit at a programmable rate, packs 32 bits
// MSB-first into words and buffers them for host reads over a cs/we bus.
module ent_word_collector
  import ent_word_collector_pkg::*;
#(
  parameter int          FIFO_DEPTH     = 8,
  parameter logic [15:0] PRESCALE_RESET = 16'h0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        noise,
  input  logic        cs,
  input  logic        we,
  input  logic [7:0]  address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        error,
  output logic [7:0]  debug
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic        sync_q1;
  logic        sync_q2;
  logic        ctrl_enable;
  logic [15:0] prescale;
  logic [15:0] overflow;
  logic [15:0] pcnt;
  logic [4:0]  bcnt;
  logic [31:0] sr;

  ctrl_state_e state;
  ctrl_state_e state_next;
  logic        sample_tick;
  logic        push_req;
  logic        overflow_inc;

  logic          illegal;
  logic          wr_ok;
  logic          wr_ctrl;
  logic          wr_prescale;
  logic          wr_overflow;
  logic          pop_ok;
  logic [31:0]   fifo_rdata;
  logic [CW-1:0] fifo_count;
  logic          fifo_full;
  logic          fifo_empty;
  logic          unused_write_bits;

  assign unused_write_bits = ^write_data[31:16];
  assign debug             = sr[7:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make both flops sample the old values,
      // giving a true two-stage chain regardless of statement order.
      sync_q1 <= noise;
      sync_q2 <= sync_q1;
    end
  end

  // Bus decode: anything flagged illegal is blocked from every side effect.
  always_comb begin
    illegal = 1'b0;
    if (cs) begin
      if (!(address inside {ADDR_CTRL, ADDR_STATUS, ADDR_PRESCALE, ADDR_DATA, ADDR_OVERFLOW}))
        illegal = 1'b1;
      else if (we && (address == ADDR_STATUS || address == ADDR_DATA))
        illegal = 1'b1;
      else if (!we && address == ADDR_DATA && fifo_empty)
        illegal = 1'b1;
    end
  end

  assign error       = illegal;
  assign wr_ok       = cs && we && !illegal;
  assign wr_ctrl     = wr_ok && (address == ADDR_CTRL);
  assign wr_prescale = wr_ok && (address == ADDR_PRESCALE);
  assign wr_overflow = wr_ok && (address == ADDR_OVERFLOW);
  assign pop_ok      = cs && !we && !illegal && (address == ADDR_DATA);

  always_comb begin
    read_data = '0;
    if (!illegal) begin
      case (address)
        ADDR_CTRL:     read_data[CTRL_ENABLE_BIT] = ctrl_enable;
        ADDR_STATUS: begin
          read_data[STATUS_AVAIL_BIT] = !fifo_empty;
          read_data[STATUS_FULL_BIT]  = fifo_full;
          read_data[STATUS_COUNT_MSB:STATUS_COUNT_LSB] = 5'(fifo_count);
        end
        ADDR_PRESCALE: read_data[15:0] = prescale;
        ADDR_DATA:     if (!fifo_empty) read_data = fifo_rdata;
        ADDR_OVERFLOW: read_data[15:0] = overflow;
        default:       ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= CTRL_IDLE;
    else          state <= state_next;
  end

  // A CTRL write in the 32nd-bit cycle restarts collection, so no PUSH follows.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves a
    // variable unassigned, which would otherwise infer a latch.
    state_next  = state;
    sample_tick = 1'b0;
    push_req    = 1'b0;
    case (state)
      CTRL_IDLE: if (ctrl_enable) state_next = CTRL_SAMPLE;
      CTRL_SAMPLE: begin
        if (!ctrl_enable) begin
          state_next = CTRL_IDLE;
        end else if (pcnt == prescale) begin
          sample_tick = 1'b1;
          if (bcnt == 5'd31 && !wr_ctrl) state_next = CTRL_PUSH;
        end
      end
      CTRL_PUSH: begin
        push_req   = 1'b1;
        state_next = ctrl_enable ? CTRL_SAMPLE : CTRL_IDLE;
      end
      default: state_next = CTRL_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pcnt <= '0;
      bcnt <= '0;
      sr   <= '0;
    end else begin
      if (state == CTRL_SAMPLE && ctrl_enable) begin
        if (sample_tick) begin
          pcnt <= '0;
          bcnt <= bcnt + 5'd1;
          sr   <= {sr[30:0], sync_q2};
        end else begin
          pcnt <= pcnt + 16'd1;
        end
      end else begin
        pcnt <= '0;
        bcnt <= '0;
      end
      if (wr_ctrl) begin
        bcnt <= '0;
        sr   <= '0;
      end
    end
  end

  assign overflow_inc = push_req && fifo_full && !pop_ok;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_enable <= 1'b0;
      prescale    <= PRESCALE_RESET;
      overflow    <= '0;
    end else begin
      if (wr_ctrl)     ctrl_enable <= write_data[CTRL_ENABLE_BIT];
      if (wr_prescale) prescale    <= write_data[15:0];
      if (wr_overflow)
        overflow <= '0;
      else if (overflow_inc && overflow != 16'hFFFF)
        overflow <= overflow + 16'd1;
    end
  end

  ent_sync_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push_req),
    .pop     (pop_ok),
    .wdata   (sr),
    .rdata   (fifo_rdata),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

endmodule

// File: doc/ent_word_collector.md
# ent_word_collector

Collects raw bits from an on-chip noise source, packs them MSB-first into 32-bit words and buffers the words in a small FIFO. Host software reads the words over the 32-bit cs/we/address memory-like interface, addressed by coretest through the top-level address mux. The block sits directly downstream of the noise source and directly upstream of coretest.

## Interface
- FIFO_DEPTH, 8: words buffered; power of two, 2..16.
- PRESCALE_RESET, 16'h0000: reset value of the PRESCALE register.
- clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- noise  in  1  raw asynchronous noise bit.
- cs  in  1  access strobe, one cycle per access.
- we  in  1  1 = write, 0 = read; qualified by cs.
- address  in  8  register address.
- write_data  in  32  write data.
- read_data  out  32  read data; combinational from address and registers.
- error  out  1  combinational; high in the cycle of an illegal access.
- debug  out  8  shift register bits [7:0].

## Operation
- Register map:
  - 0x00 CTRL, RW: bit0 enable. Any write clears the shift register and bit counter.
  - 0x01 STATUS, RO: bit0 avail (count != 0), bit1 full, bits[12:8] count.
  - 0x02 PRESCALE, RW [15:0]: one sample every PRESCALE+1 clocks.
  - 0x03 DATA, RO: FIFO head; a read pops it.
  - 0x04 OVERFLOW, RO [15:0]: dropped-word count, saturates at 16'hFFFF. A write of any value clears it; this is the only legal write to an RO address.
- Illegal accesses, which assert error, return 0 and have no side effects:
  - writes to 0x01 or 0x03;
  - any access to an unmapped address;
  - a DATA read while the FIFO is empty.
- Synchronizer: two flops on noise. The sampled bit is the second flop.
- Collect FSM:
  - IDLE: enable = 0. Prescale counter and bit counter are held at 0.
  - IDLE -> SAMPLE when enable = 1.
  - SAMPLE: the prescale counter counts up. When it equals PRESCALE, the shift register takes {sr[30:0], bit}, the bit counter increments and the prescale counter returns to 0.
  - SAMPLE -> PUSH when the 32nd bit enters.
  - PUSH: lasts one cycle. The word is pushed if the FIFO is not full; otherwise OVERFLOW increments and the word is dropped. Counters clear. PUSH -> SAMPLE, or -> IDLE if enable = 0.
  - enable = 0 in SAMPLE: -> IDLE and the partial word is discarded.
- PRESCALE written mid-collection takes effect from the next comparison. If the counter is already above the new value, it continues counting, wraps at 16 bits and then matches.
- Push and pop in the same cycle:
  - count is unchanged;
  - this is legal when full, because the pop frees the slot first and no overflow occurs;
  - a pop of an empty FIFO is rejected even if a push occurs in the same cycle.
- Read pointer and write pointer are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. count is a separate register of width log2(FIFO_DEPTH)+1.

## Timing
- Reset values:
  - read_data = 0 and error = 0 (outputs follow combinationally);
  - debug = 0;
  - CTRL = 0, PRESCALE = PRESCALE_RESET, OVERFLOW = 0;
  - FIFO empty, FSM in IDLE, synchronizer flops = 0.
- Reset mid-operation discards the partial word and all FIFO contents immediately.
- Noise-to-sample latency: 2 clocks through the synchronizer.
- With PRESCALE = P, a word is pushed 32·(P+1)+1 clocks after entering SAMPLE; the +1 is the PUSH cycle.
- After a push at edge N, avail is visible from N+1.
- DATA read: data is valid in the cs cycle. The pop takes effect at the closing edge, so the next read sees the next word.
- Register writes take effect at the closing edge of the cs cycle.

## Structure
- Package ent_word_collector_pkg holds:
  - address constants ADDR_CTRL, ADDR_STATUS, ADDR_PRESCALE, ADDR_DATA, ADDR_OVERFLOW;
  - CTRL and STATUS bit indices;
  - FSM state encodings CTRL_IDLE, CTRL_SAMPLE, CTRL_PUSH.
- Sub-module ent_sync_fifo is a synchronous 32-bit FIFO:
  - parameter DEPTH;
  - ports push, pop, wdata, rdata, count, full, empty;
  - internal pop-of-empty guard.
- The top level contains the synchronizer, the FSM, the prescaler, the shift register, the registers and the read mux.

## Test plan
- Reset, then read STATUS -> 0x00000000. Read PRESCALE -> PRESCALE_RESET. Read DATA -> 0 with error = 1.
- noise tied to 1, PRESCALE = 0, enable:
  - STATUS avail = 1 at 33 clocks after SAMPLE entry (plus 2 synchronizer clocks);
  - DATA read -> 32'hFFFFFFFF.
- Driven pattern 1010… at one bit per 4 clocks, PRESCALE = 3:
  - first word 32'hAAAAAAAA or 32'h55555555, depending on phase;
  - debug tracks the low byte of the shift register.
- Fill 8 words without reading:
  - full = 1, count = 8;
  - two more words -> OVERFLOW = 2, and the FIFO contents are unchanged;
  - write OVERFLOW -> reads 0.
- FIFO full, DATA read coinciding with a PUSH cycle -> count stays 8, no overflow, and the read returns the oldest word.
- Error cases:
  - write to 0x03 -> error = 1 and the FIFO is untouched;
  - read of 0x20 -> 0 with error = 1;
  - enable cleared mid-word, then set again -> the next word consists only of fresh bits;
  - reset asserted mid-collection -> all registers at their reset values.
